// File: rtl/loader_pkg.sv
// Shared types and constants for the framed code loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN_LO,
    GET_LEN_HI,
    PAYLOAD,
    GET_CSUM,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } loader_err_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter flagging an over-long silence between received bytes.
module gap_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Loaded with TIMEOUT-1 so zero is reached on the TIMEOUT-th clock after the byte.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/code_loader.sv
// Framed program loader: SYNC, LEN_LO, LEN_HI, payload, CSUM -> code RAM writes.
// state      | meaning
// IDLE       | waiting for SYNC; prog_ready holds the last result
// GET_LEN_LO | collecting low length byte
// GET_LEN_HI | collecting high length byte, validating length
// PAYLOAD    | writing bytes to RAM, accumulating sum
// GET_CSUM   | checking final checksum byte
// ERROR      | last frame failed; waiting for SYNC
module code_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         GAP_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              prog_ready,
  output logic              load_busy,
  output logic              load_error,
  output logic [1:0]        err_code
);

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  loader_state_t     state_q, state_n;
  loader_err_t       err_q, err_n;
  logic [15:0]       len_q, len_n;
  logic [ADDR_W:0]   addr_q, addr_n;
  logic [7:0]        sum_q, sum_n;
  logic              prog_q, prog_n;
  logic              wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [7:0]        wr_data_q, wr_data_n;

  logic              busy, expired, sync_hit;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   addr_next;
  logic [7:0]        sum_plus;

  assign busy      = (state_q == GET_LEN_LO) || (state_q == GET_LEN_HI) ||
                     (state_q == PAYLOAD)    || (state_q == GET_CSUM);
  assign sync_hit  = rx_valid && (rx_data == SYNC_BYTE);
  assign len_full  = {rx_data, len_q[7:0]};
  assign addr_next = addr_q + 1'b1;
  assign sum_plus  = sum_q + rx_data;

  gap_timer #(.TIMEOUT(GAP_TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (rx_valid),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      len_q     <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      prog_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_n;
      err_q     <= err_n;
      len_q     <= len_n;
      addr_q    <= addr_n;
      sum_q     <= sum_n;
      prog_q    <= prog_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    err_n     = err_q;
    len_n     = len_q;
    addr_n    = addr_q;
    sum_n     = sum_q;
    prog_n    = prog_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    case (state_q)
      IDLE, ERROR: begin
        if (sync_hit) begin
          state_n = GET_LEN_LO;
          err_n   = ERR_NONE;
          prog_n  = 1'b0;
        end
      end
      GET_LEN_LO: begin
        if (rx_valid) begin
          len_n   = {8'h00, rx_data};
          state_n = GET_LEN_HI;
        end
      end
      GET_LEN_HI: begin
        if (rx_valid) begin
          len_n = len_full;
          if ((len_full == 16'h0000) || ({1'b0, len_full} > MAX_LEN)) begin
            state_n = ERROR;
            err_n   = ERR_LEN;
          end else begin
            addr_n  = '0;
            sum_n   = '0;
            state_n = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_q[ADDR_W-1:0];
          wr_data_n = rx_data;
          addr_n    = addr_next;
          sum_n     = sum_plus;
          if (17'(addr_next) == {1'b0, len_q}) begin
            state_n = GET_CSUM;
          end
        end
      end
      GET_CSUM: begin
        if (rx_valid) begin
          if (sum_plus == 8'h00) begin
            state_n = IDLE;
            prog_n  = 1'b1;
          end else begin
            state_n = ERROR;
            err_n   = ERR_CSUM;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A byte on the expiry cycle takes priority over the timeout.
    if (busy && expired && !rx_valid) begin
      state_n = ERROR;
      err_n   = ERR_TIMEOUT;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign prog_ready = prog_q;
  assign load_busy  = busy;
  assign load_error = (err_q != ERR_NONE);
  assign err_code   = err_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: frame-position model plus directed frames.
module tb_code_loader;

  localparam int         ADDR_W = 8;
  localparam int         GAP    = 16;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              prog_ready;
  logic              load_busy;
  logic              load_error;
  logic [1:0]        err_code;

  code_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .GAP_TIMEOUT(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .prog_ready (prog_ready),
    .load_busy  (load_busy),
    .load_error (load_error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: position of the next byte within the current frame.
  bit m_busy = 0;
  int m_pos = 0, m_len = 0, m_sum = 0, m_gap = 0;
  bit m_prog = 0;
  int m_err = 0;
  bit m_wr = 0;
  int m_waddr = 0, m_wdata = 0;

  logic [7:0] ram [256];
  int  wr_count = 0;
  bit  started  = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit r, bit v, logic [7:0] d);
    m_wr = 0;
    if (!r) begin
      m_busy = 0; m_prog = 0; m_err = 0; m_waddr = 0; m_wdata = 0; m_gap = 0;
      return;
    end
    if (v) begin
      m_gap = 0;
      if (!m_busy) begin
        if (d == SYNC) begin
          m_busy = 1; m_pos = 0; m_prog = 0; m_err = 0;
        end
      end else begin
        if (m_pos == 0) begin
          m_len = int'(d);
        end else if (m_pos == 1) begin
          m_len = m_len + 256 * int'(d);
          m_sum = 0;
          if (m_len == 0 || m_len > 256) begin
            m_busy = 0; m_err = 1;
          end
        end else if (m_pos < m_len + 2) begin
          m_wr = 1; m_waddr = m_pos - 2; m_wdata = int'(d);
          m_sum = m_sum + int'(d);
        end else begin
          m_busy = 0;
          if ((m_sum + int'(d)) % 256 == 0) m_prog = 1;
          else m_err = 2;
        end
        m_pos++;
      end
    end else if (m_busy) begin
      m_gap++;
      if (m_gap >= GAP) begin
        m_busy = 0; m_err = 3;
      end
    end
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(rst, v, d);
    #1;
  endtask

  task automatic send(input bq_t q);
    foreach (q[i]) cyc(1'b1, q[i]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("wr_en", int'(wr_en), int'(m_wr));
      chk("wr_addr", int'(wr_addr), m_waddr);
      chk("wr_data", int'(wr_data), m_wdata);
      chk("prog_ready", int'(prog_ready), int'(m_prog));
      chk("load_busy", int'(load_busy), int'(m_busy));
      chk("load_error", int'(load_error), int'(m_err != 0));
      chk("err_code", int'(err_code), m_err);
      if (wr_en) begin
        ram[wr_addr] <= wr_data;
        wr_count     <= wr_count + 1;
      end
    end
  end

  initial begin
    bq_t q;
    int  n0;

    rst = 1'b0;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    started = 1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_prog_ready", int'(prog_ready), 0);
    chk("rst_busy_err", int'({load_busy, load_error, err_code}), 0);

    rst = 1'b1;
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00); cyc(1'b0, 8'h00); cyc(1'b1, 8'hFF); cyc(1'b1, 8'h5A); cyc(1'b0, 8'h00);
    chk("noise_busy", int'(load_busy), 0);

    // Good 4-byte frame: 11+22+33+44 = AA, so CSUM 56 closes the sum.
    n0 = wr_count;
    q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send(q);
    chk("prog_before_csum", int'(prog_ready), 0);
    cyc(1'b1, 8'h56);
    chk("prog_after_csum", int'(prog_ready), 1);
    chk("good_err_code", int'(err_code), 0);
    chk("good_wr_count", wr_count - n0, 4);
    chk("ram0", int'(ram[0]), 'h11);
    chk("ram1", int'(ram[1]), 'h22);
    chk("ram2", int'(ram[2]), 'h33);
    chk("ram3", int'(ram[3]), 'h44);
    chk("model_prog", int'(m_prog), 1);

    cyc(1'b1, SYNC);
    chk("prog_drop_on_sync", int'(prog_ready), 0);
    chk("busy_after_sync", int'(load_busy), 1);
    q = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h57};
    send(q);
    chk("csum_err_code", int'(err_code), 2);
    chk("csum_load_error", int'(load_error), 1);
    chk("csum_prog", int'(prog_ready), 0);

    cyc(1'b1, SYNC);
    chk("sync_clears_error", int'(load_error), 0);
    q = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    send(q);
    chk("recover_prog", int'(prog_ready), 1);
    chk("recover_error", int'(load_error), 0);

    n0 = wr_count;
    q = '{8'hA5, 8'h00, 8'h00};
    send(q);
    cyc(1'b0, 8'h00);
    chk("len0_err_code", int'(err_code), 1);
    chk("len0_no_writes", wr_count - n0, 0);

    q = '{8'hA5, 8'h01, 8'h01};
    send(q);
    chk("len257_err_code", int'(err_code), 1);

    // 256-byte image of 0..255: sum mod 256 is 80, so CSUM is 80.
    q = '{8'hA5, 8'h00, 8'h01};
    send(q);
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i));
    cyc(1'b1, 8'h80);
    chk("full_prog", int'(prog_ready), 1);
    chk("full_last_addr", int'(wr_addr), 'hFF);
    chk("full_ram0", int'(ram[0]), 'h00);
    chk("full_ram128", int'(ram[128]), 'h80);
    chk("full_ram255", int'(ram[255]), 'hFF);

    q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22};
    send(q);
    repeat (GAP - 1) cyc(1'b0, 8'h00);
    chk("gap_not_yet", int'(err_code), 0);
    chk("gap_still_busy", int'(load_busy), 1);
    cyc(1'b0, 8'h00);
    chk("timeout_err_code", int'(err_code), 3);
    chk("timeout_busy", int'(load_busy), 0);

    q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22};
    send(q);
    repeat (GAP - 1) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h33);
    chk("expiry_byte_wins", int'(err_code), 0);
    chk("expiry_busy", int'(load_busy), 1);
    cyc(1'b1, 8'h44);
    cyc(1'b1, 8'h56);
    chk("expiry_frame_prog", int'(prog_ready), 1);

    q = '{8'hA5, 8'h04, 8'h00, 8'h11};
    send(q);
    rst = 1'b0;
    cyc(1'b1, 8'h22);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_addr", int'(wr_addr), 0);
    chk("midrst_wr_data", int'(wr_data), 0);
    chk("midrst_flags", int'({prog_ready, load_busy, load_error, err_code}), 0);
    rst = 1'b1;
    cyc(1'b0, 8'h00);
    q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    send(q);
    chk("after_rst_prog", int'(prog_ready), 1);
    cyc(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
